// File: rtl/ac_pkg.sv
// Shared Aho-Corasick table definitions: widths, sentinel states and the
// writer FSM encoding, common to the writer, the readers and the failure builder.
package ac_pkg;

  localparam int unsigned STATE_W    = 8;
  localparam int unsigned CHAR_W     = 4;
  localparam int unsigned ADDR_W     = STATE_W + CHAR_W;
  localparam int unsigned ID_W       = 8;

  localparam int unsigned ROOT_STATE = 0;
  localparam int unsigned NO_EDGE    = 0;

  typedef enum logic [1:0] {
    ST_CLEAR_SWEEP = 2'd0,
    ST_IDLE        = 2'd1,
    ST_LOOKUP      = 2'd2,
    ST_CHECK       = 2'd3
  } ac_state_e;

endpackage

// File: rtl/goto_table_writer.sv
// Builds the Aho-Corasick goto trie and output table: sweeps goto memory to
// zero, then inserts keywords one character per three cycles.
module goto_table_writer #(
  parameter int unsigned STATE_W = ac_pkg::STATE_W,
  parameter int unsigned CHAR_W  = ac_pkg::CHAR_W,
  parameter int unsigned ADDR_W  = STATE_W + CHAR_W,
  parameter int unsigned ID_W    = ac_pkg::ID_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLEAR,
  input  logic               KW_VALID,
  output logic               KW_READY,
  input  logic [CHAR_W-1:0]  KW_CHARA,
  input  logic               KW_LAST,
  output logic               MEM_RE,
  output logic               MEM_WE,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic [STATE_W-1:0] MEM_WDATA,
  input  logic [STATE_W-1:0] MEM_RDATA,
  output logic               OUT_WE,
  output logic [STATE_W-1:0] OUT_ADDR,
  output logic [ID_W-1:0]    OUT_ID,
  output logic               BUSY,
  output logic               ERR_FULL,
  output logic [STATE_W:0]   NUM_STATES
);

  import ac_pkg::*;

  ac_state_e            state, state_nxt;
  logic [ADDR_W-1:0]    sweep_cnt;
  logic [STATE_W-1:0]   cur;
  logic [CHAR_W-1:0]    chara;
  logic                 last;
  logic [ID_W-1:0]      kw_id;
  logic [STATE_W:0]     num_states;
  logic                 err_full;
  logic                 kw_drop;

  logic                 hit, full, alloc, drop_now, sweep_done;
  logic [STATE_W-1:0]   nxt;

  // num_states never exceeds 2^STATE_W, so its MSB alone marks a full table
  assign hit        = (MEM_RDATA != STATE_W'(NO_EDGE));
  assign full       = num_states[STATE_W];
  assign alloc      = !kw_drop && !hit && !full;
  assign drop_now   = kw_drop || (!hit && full);
  assign nxt        = hit ? MEM_RDATA : num_states[STATE_W-1:0];
  assign sweep_done = (sweep_cnt == '1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_CLEAR_SWEEP;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    KW_READY  = 1'b0;
    MEM_RE    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = {cur, chara};
    MEM_WDATA = '0;
    OUT_WE    = 1'b0;
    OUT_ADDR  = '0;
    case (state)
      ST_CLEAR_SWEEP: begin
        // gated by RST so no write strobe is presented while reset is held
        MEM_WE   = RST;
        MEM_ADDR = sweep_cnt;
        if (sweep_done) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        KW_READY = !CLEAR;
        if (CLEAR)         state_nxt = ST_CLEAR_SWEEP;
        else if (KW_VALID) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        MEM_RE    = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        MEM_WE    = alloc;
        MEM_WDATA = num_states[STATE_W-1:0];
        OUT_WE    = last && !drop_now;
        OUT_ADDR  = nxt;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR_SWEEP;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sweep_cnt  <= '0;
      cur        <= STATE_W'(ROOT_STATE);
      chara      <= '0;
      last       <= 1'b0;
      kw_id      <= '0;
      num_states <= (STATE_W+1)'(1);
      err_full   <= 1'b0;
      kw_drop    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR_SWEEP: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_done) begin
            num_states <= (STATE_W+1)'(1);
            err_full   <= 1'b0;
            kw_id      <= '0;
            cur        <= STATE_W'(ROOT_STATE);
            kw_drop    <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (CLEAR) begin
            sweep_cnt <= '0;
          end else if (KW_VALID) begin
            chara <= KW_CHARA;
            last  <= KW_LAST;
          end
        end
        ST_CHECK: begin
          if (alloc) num_states <= num_states + 1'b1;
          if (!kw_drop && !hit && full) err_full <= 1'b1;
          // an exhausted keyword freezes cur until its last beat returns to root
          if (last) begin
            kw_id   <= kw_id + 1'b1;
            cur     <= STATE_W'(ROOT_STATE);
            kw_drop <= 1'b0;
          end else if (!drop_now) begin
            cur <= nxt;
          end else begin
            kw_drop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY       = (state != ST_IDLE);
  assign OUT_ID     = kw_id;
  assign ERR_FULL   = err_full;
  assign NUM_STATES = num_states;

endmodule

// File: tb/tb_goto_table_writer.sv
// Randomized bench for goto_table_writer: a keyword-level trie model predicts
// every memory/output-table write, with directed sweep, duplicate and CLEAR cases.
module tb_goto_table_writer;

  localparam int SW = 8;
  localparam int CW = 4;
  localparam int AW = SW + CW;
  localparam int IW = 8;
  localparam int MAX_STATES = 1 << SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          kw_valid = 1'b0;
  logic          kw_last = 1'b0;
  logic [CW-1:0] kw_chara = '0;
  logic          kw_ready, mem_re, mem_we, out_we, busy, err_full;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata, out_addr;
  logic [SW-1:0] mem_rdata = '0;
  logic [IW-1:0] out_id;
  logic [SW:0]   num_states;

  logic [SW-1:0] gmem [1<<AW];

  int n_checks = 0;
  int n_pass   = 0;

  // keyword-level reference model: trie as an associative edge map
  int gto [int];
  int m_nst, m_id, m_cur;
  bit m_full;

  goto_table_writer #(.STATE_W(SW), .CHAR_W(CW), .ADDR_W(AW), .ID_W(IW)) dut (
    .CLK(clk), .RST(rst_n), .CLEAR(clear),
    .KW_VALID(kw_valid), .KW_READY(kw_ready), .KW_CHARA(kw_chara), .KW_LAST(kw_last),
    .MEM_RE(mem_re), .MEM_WE(mem_we), .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata),
    .OUT_WE(out_we), .OUT_ADDR(out_addr), .OUT_ID(out_id),
    .BUSY(busy), .ERR_FULL(err_full), .NUM_STATES(num_states)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) gmem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= gmem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic model_clear();
    gto.delete();
    m_nst  = 1;
    m_id   = 0;
    m_cur  = 0;
    m_full = 0;
  endtask

  // counts consecutive sweep writes starting at the current sample point
  task automatic sweep_check();
    int nwr = 0;
    int bad = 0;
    int nonzero = 0;
    for (int k = 0; k < 5000; k++) begin
      if (!mem_we) break;
      if (mem_addr != AW'(nwr) || mem_wdata != '0) bad++;
      nwr++;
      @(negedge clk); #1;
    end
    check("sweep_len", nwr, 1 << AW);
    check("sweep_addr_data", bad, 0);
    check("sweep_ready", kw_ready, 1);
    check("sweep_busy", busy, 0);
    check("sweep_num_states", num_states, 1);
    check("sweep_err_full", err_full, 0);
    for (int a = 0; a < (1 << AW); a++) if (gmem[a] != '0) nonzero++;
    check("sweep_mem_zero", nonzero, 0);
  endtask

  // one accepted beat: LOOKUP at t+1, CHECK at t+2, ready again at t+3
  task automatic beat(input int c, input bit last, input int exp_addr,
                      input bit exp_we, input int exp_wdata,
                      input bit exp_out, input int exp_oaddr, input int exp_oid);
    kw_chara = CW'(c);
    kw_last  = last;
    kw_valid = 1'b1;
    #1 check("beat_ready", kw_ready, 1);
    @(posedge clk);
    @(negedge clk);
    kw_valid = 1'b0;
    #1;
    check("lookup_re", mem_re, 1);
    check("lookup_we", mem_we, 0);
    check("lookup_addr", mem_addr, exp_addr);
    @(negedge clk); #1;
    check("check_re", mem_re, 0);
    check("check_we", mem_we, exp_we);
    if (exp_we) begin
      check("check_waddr", mem_addr, exp_addr);
      check("check_wdata", mem_wdata, exp_wdata);
    end
    check("check_out_we", out_we, exp_out);
    if (exp_out) begin
      check("out_addr", out_addr, exp_oaddr);
      check("out_id", out_id, exp_oid);
    end
    @(negedge clk); #1;
    check("ready_t3", kw_ready, 1);
  endtask

  task automatic send_kw(input int q[$], input bit with_last);
    bit dropped = 0;
    for (int i = 0; i < q.size(); i++) begin
      int c    = q[i];
      bit last = with_last && (i == q.size() - 1);
      int key  = m_cur * (1 << CW) + c;
      bit we   = 0;
      int wd   = 0;
      int nxt  = 0;
      if (!dropped) begin
        if (gto.exists(key)) nxt = gto[key];
        else if (m_nst < MAX_STATES) begin
          nxt = m_nst;
          gto[key] = m_nst;
          m_nst++;
          we = 1;
          wd = nxt;
        end else begin
          dropped = 1;
          m_full  = 1;
        end
      end
      if (!last && !dropped) m_cur = nxt;
      beat(c, last, key, we, wd, last && !dropped, nxt, m_id);
      if (last) begin
        m_id  = (m_id + 1) % (1 << IW);
        m_cur = 0;
      end
    end
    check("num_states", num_states, m_nst);
    check("err_full", err_full, m_full);
  endtask

  task automatic rand_kw(input int len, input int alpha);
    int q[$];
    for (int i = 0; i < len; i++) q.push_back($urandom_range(alpha - 1, 0));
    send_kw(q, 1);
  endtask

  initial begin
    int q[$];
    for (int a = 0; a < (1 << AW); a++) gmem[a] = SW'($urandom);
    model_clear();

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_num_states", num_states, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_out_we", out_we, 0);
    check("rst_ready", kw_ready, 0);
    check("rst_err_full", err_full, 0);
    rst_n = 1'b1;
    #1;
    sweep_check();

    q = {4, 5}; send_kw(q, 1);
    q = {4, 9}; send_kw(q, 1);
    q = {4, 5}; send_kw(q, 1);

    for (int k = 0; k < 25; k++) rand_kw($urandom_range(5, 1), 4);
    while (m_nst < MAX_STATES) rand_kw(12, 16);
    for (int k = 0; k < 4; k++) rand_kw($urandom_range(3, 1), 4);
    rand_kw(10, 16);
    q = {1}; send_kw(q, 1);

    // partial keyword, then CLEAR held against a valid beat
    q = {3}; send_kw(q, 0);
    kw_chara = 4'd5;
    kw_last  = 1'b1;
    kw_valid = 1'b1;
    clear    = 1'b1;
    #1 check("clear_ready", kw_ready, 0);
    @(posedge clk);
    @(negedge clk);
    clear    = 1'b0;
    kw_valid = 1'b0;
    #1;
    check("clear_busy", busy, 1);
    check("clear_no_lookup", mem_re, 0);
    sweep_check();
    model_clear();

    q = {4, 5}; send_kw(q, 1);
    for (int k = 0; k < 10; k++) rand_kw($urandom_range(4, 1), 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
